t07_memory_handler: RTL and testbench
=====================================

# t07_memory_handler

Sequential responder for the control unit's memory-control outputs (`memRead`, `memWrite`, `memOp`). It turns one decoded load/store into a single word-aligned bus transaction with byte enables. It stalls the PC until the transaction completes, then returns the sign- or zero-extended load data to the register write-back mux (`regWriteSrc = 3'b001`). It sits between the control unit/ALU and the external data-memory bus.

## Interface
Parameters: none (32-bit datapath fixed).
- `clk`  in  1  system clock
- `nrst`  in  1  reset: synchronous, active-low
- `memRead`  in  1  load request from control unit
- `memWrite`  in  1  store request from control unit
- `memOp`  in  4  encoding:
  - 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw
  - any other value is invalid
- `addr`  in  32  effective address (ALU result)
- `storeData`  in  32  rs2 value for stores
- `bus_rdata`  in  32  read data; valid when `bus_ack`=1
- `bus_ack`  in  1  transaction complete
- `bus_read`  out  1  read strobe
- `bus_write`  out  1  write strobe
- `bus_addr`  out  32  `{addr[31:2],2'b00}`
- `bus_wdata`  out  32  lane-replicated store data
- `bus_sel`  out  4  byte enables
- `loadData`  out  32  extended load result to write-back mux
- `stall`  out  1  freeze PC/pipeline while high
- `err`  out  1  one-cycle pulse: misaligned access, invalid `memOp`, or `memRead` and `memWrite` both high

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- A request is `memRead | memWrite`, evaluated in IDLE only.
- IDLE, request, legal access:
  - `stall`=1 combinationally.
  - Register `bus_addr`, `bus_sel` and `bus_wdata`; latch op type and `addr[1:0]`.
  - Transition to BUSY.
- IDLE, request, illegal access:
  - Illegal means: misaligned access (half with `addr[0]`=1; word with `addr[1:0]`≠0), `memOp` outside the load set 1-5 with `memRead`, `memOp` outside the store set 6-8 with `memWrite`, or both strobes high.
  - `stall`=1 combinationally; go to DONE with the error flag set. No bus strobe is ever raised.
- BUSY:
  - Hold `bus_read` (loads) or `bus_write` (stores) high, together with the address, data and select values.
  - Stay in BUSY while `bus_ack`=0; `stall`=1.
  - On `bus_ack`=1: for a load, capture the extended `bus_rdata` into `loadData`; go to DONE.
- DONE:
  - Strobes low, `stall`=0, `err`=1 only if the error flag is set.
  - Unconditionally return to IDLE.
  - The request inputs are ignored in DONE, because they still carry the same instruction; this prevents a re-trigger.
- Byte enables and store data (k = `addr[1:0]`):
  - byte: `bus_sel` = 1<<k, `bus_wdata` = {4{storeData[7:0]}}
  - half: `bus_sel` = 0011 (k=0) or 1100 (k=2), `bus_wdata` = {2{storeData[15:0]}}
  - word: `bus_sel` = 1111, `bus_wdata` = storeData
- Load extraction:
  - Select the byte lane k, or the half lane k[1].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
- `loadData` holds its value until the next successful load; stores and errors leave it unchanged.
- `bus_wdata` is don't-care for loads; drive it to 0.

## Timing
- Reset (`nrst`=0 at a rising edge): state IDLE; `bus_read`, `bus_write`, `stall`, `err` = 0; `bus_addr`, `bus_wdata`, `bus_sel`, `loadData` = 0.
- Reset mid-BUSY aborts the transaction: strobes drop the next cycle, `bus_ack` is ignored, no data is captured.
- Legal access, request in cycle N with `bus_ack` in cycle N+k (k≥1):
  - Strobe high in cycles N+1..N+k.
  - DONE in N+k+1: `stall` low, `loadData` valid.
  - `stall` is high for cycles N..N+k.
- Minimum legal latency: 2 stall cycles.
- Illegal access: `stall` high in cycle N only; `err` high in cycle N+1; zero bus cycles.
- `bus_ack` while in IDLE or DONE is ignored.
- A request with no strobe asserted never raises `stall`.

## Test plan
- lw, `addr`=0x100, `bus_ack` 2 cycles after the strobe, `bus_rdata`=0xDEADBEEF:
  - `bus_addr`=0x100, `bus_sel`=1111, `bus_read` high for 2 cycles, `stall` high for 3 cycles, then `loadData`=0xDEADBEEF.
- lb and lbu, `addr`=0x103, `bus_rdata`=0x80FF0000, immediate ack:
  - `bus_sel`=1000; `loadData` = 0xFFFFFF80 for lb, 0x00000080 for lbu.
- sh, `addr`=0x102, `storeData`=0x1234ABCD:
  - `bus_addr`=0x100, `bus_sel`=1100, `bus_wdata`=0xABCDABCD, `bus_write` held until ack; `loadData` unchanged.
- lw at 0x102, then memOp=9 with `memRead`, then `memRead`=`memWrite`=1:
  - each gives a one-cycle `stall`, then a one-cycle `err`; no bus strobe; `loadData` unchanged.
- Back-to-back requests (sb at 0x201, byte 0x5A; then lhu at 0x202, `bus_rdata`=0x8001xxxx):
  - sb: `bus_sel`=0010, `bus_wdata`=0x5A5A5A5A.
  - lhu: `loadData`=0x00008001.
  - No duplicate transaction while DONE sees stale inputs.
- `nrst` low during BUSY with `bus_ack` arriving the same cycle:
  - all outputs return to reset values; `loadData`=0; the next request proceeds normally.

Source files
------------

// File: rtl/t07_memory_handler.sv
// t07_memory_handler: turns one decoded load/store into a single word-aligned
// bus transaction with byte enables, stalls the PC until it completes and
// returns the extended load data to the write-back mux.
//
// Ports:
//   clk, nrst                  clock, synchronous active-low reset
//   memRead, memWrite, memOp   request from the control unit (memOp 1..8 = lb..sw)
//   addr, storeData            effective address and store operand
//   bus_rdata, bus_ack         read data and transaction completion from memory
//   bus_read, bus_write        bus strobes, held high while BUSY
//   bus_addr, bus_wdata, bus_sel   word address, lane-replicated data, byte enables
//   loadData                   extended load result, held until the next load
//   stall                      freeze PC/pipeline
//   err                        one-cycle pulse for an illegal access
module t07_memory_handler (
    input  logic        clk,
    input  logic        nrst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [3:0]  memOp,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic [31:0] loadData,
    output logic        stall,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  k_q, k_d;
    logic        err_q, err_d;

    logic        req, is_byte, is_half, is_word, ld_ok, st_ok, illegal, is_load;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext;

    always_comb begin
        req     = memRead | memWrite;
        is_byte = (memOp == 4'd1) || (memOp == 4'd4) || (memOp == 4'd6);
        is_half = (memOp == 4'd2) || (memOp == 4'd5) || (memOp == 4'd7);
        is_word = (memOp == 4'd3) || (memOp == 4'd8);
        ld_ok   = (memOp >= 4'd1) && (memOp <= 4'd5);
        st_ok   = (memOp >= 4'd6) && (memOp <= 4'd8);
        illegal = (memRead && memWrite) || (memRead && !ld_ok) || (memWrite && !st_ok) ||
                  (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00);
        // op_q only ever holds a legal code, so 1..5 identifies a load
        is_load = (op_q >= 4'd1) && (op_q <= 4'd5);
        rd_byte = 8'(bus_rdata >> {k_q, 3'b000});
        rd_half = k_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext     = (op_q == 4'd1) ? {{24{rd_byte[7]}}, rd_byte} :
                  (op_q == 4'd2) ? {{16{rd_half[15]}}, rd_half} :
                  (op_q == 4'd4) ? {24'd0, rd_byte} :
                  (op_q == 4'd5) ? {16'd0, rd_half} : bus_rdata;
    end

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        load_data_d = load_data_q;
        op_d        = op_q;
        k_d         = k_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = illegal ? DONE : BUSY;
                err_d   = illegal;
                if (!illegal) begin
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_sel_d   = is_byte ? 4'b0001 << addr[1:0] :
                                  is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                    bus_wdata_d = memRead ? 32'd0 :
                                  is_byte ? {4{storeData[7:0]}} :
                                  is_half ? {2{storeData[15:0]}} : storeData;
                    op_d        = memOp;
                    k_d         = addr[1:0];
                end
            end
            BUSY: if (bus_ack) begin
                state_d = DONE;
                if (is_load) load_data_d = ext;
            end
            // DONE ignores the still-asserted request of the same instruction
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_sel_q   <= 4'd0;
            load_data_q <= 32'd0;
            op_q        <= 4'd0;
            k_q         <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            load_data_q <= load_data_d;
            op_q        <= op_d;
            k_q         <= k_d;
            err_q       <= err_d;
        end
    end

    assign bus_read  = (state_q == BUSY) && is_load;
    assign bus_write = (state_q == BUSY) && !is_load;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign loadData  = load_data_q;
    assign stall     = ((state_q == IDLE) && req) || (state_q == BUSY);
    assign err       = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_t07_memory_handler.sv
// tb_t07_memory_handler: directed scoreboard bench for t07_memory_handler.
module tb_t07_memory_handler;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [3:0]  memOp = 4'd0;
    logic [31:0] addr = 32'd0, storeData = 32'd0, bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;
    logic        bus_read, bus_write, stall, err;
    logic [31:0] bus_addr, bus_wdata, loadData;
    logic [3:0]  bus_sel;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [3:0]  sel;
        logic [31:0] wd;
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    t07_memory_handler dut (
        .clk(clk), .nrst(nrst), .memRead(memRead), .memWrite(memWrite), .memOp(memOp),
        .addr(addr), .storeData(storeData), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .loadData(loadData), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        txn_t t;
        chk("txn_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("bus_write", 32'(bus_write), 32'(t.wr));
            chk("bus_read", 32'(bus_read), 32'(!t.wr));
            chk("bus_addr", bus_addr, t.a);
            chk("bus_sel", 32'(bus_sel), 32'(t.sel));
            chk("bus_wdata", bus_wdata, t.wd);
        end
    endtask

    // Drive one instruction, hold it until DONE, then check the DONE cycle.
    // Inputs are left stale through DONE, as the real pipeline would.
    task automatic run_op(input logic rd, input logic wr, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                          input int ack_after, input logic exp_err,
                          input logic [3:0] exp_sel, input logic [31:0] exp_wd,
                          input logic [31:0] exp_ld);
        int strobes = 0;
        logic done = 1'b0;
        @(negedge clk);
        memRead = rd; memWrite = wr; memOp = op; addr = a; storeData = sd; bus_ack = 1'b0;
        if (!exp_err) exp_q.push_back('{wr, {a[31:2], 2'b00}, exp_sel, exp_wd});
        #1 chk("stall_req", 32'(stall), 32'd1);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_read || bus_write) begin
                strobes++;
                if (strobes == 1) pop_check();
                chk("stall_busy", 32'(stall), 32'd1);
                if (strobes == ack_after) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end
            end else done = 1'b1;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("strobe_cycles", 32'(strobes), exp_err ? 32'd0 : 32'(ack_after));
        chk("stall_done", 32'(stall), 32'd0);
        chk("err_done", 32'(err), 32'(exp_err));
        chk("loadData", loadData, exp_ld);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", 32'({bus_read, bus_write}), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_sel", 32'(bus_sel), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_load", loadData, 32'd0);
        nrst = 1'b1;
        // no request: stall stays low and a stray ack is ignored
        @(negedge clk);
        memOp = 4'd3; bus_ack = 1'b1;
        #1 chk("idle_no_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("idle_ack_ignored", 32'({bus_read, bus_write, stall, err}), 32'd0);
        bus_ack = 1'b0;
        // lw 0x100, ack two cycles after strobe
        run_op(1, 0, 4'd3, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
        // lb / lbu at 0x103
        run_op(1, 0, 4'd1, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
        run_op(1, 0, 4'd4, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 4'b1000, 32'h0, 32'h00000080);
        // sh 0x102, ack after three strobe cycles
        run_op(0, 1, 4'd7, 32'h102, 32'h1234ABCD, 32'h0, 3, 0, 4'b1100, 32'hABCDABCD, 32'h00000080);
        // illegal accesses
        run_op(1, 0, 4'd3, 32'h102, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h00000080);
        run_op(1, 0, 4'd9, 32'h100, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h00000080);
        run_op(1, 1, 4'd3, 32'h100, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h00000080);
        run_op(0, 1, 4'd7, 32'h101, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h00000080);
        run_op(0, 1, 4'd3, 32'h100, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0, 32'h00000080);
        // back-to-back: sb then lhu
        run_op(0, 1, 4'd6, 32'h201, 32'h0000005A, 32'h0, 1, 0, 4'b0010, 32'h5A5A5A5A, 32'h00000080);
        run_op(1, 0, 4'd5, 32'h202, 32'h0, 32'h80011234, 1, 0, 4'b1100, 32'h0, 32'h00008001);
        run_op(1, 0, 4'd2, 32'h100, 32'h0, 32'h1234F00D, 2, 0, 4'b0011, 32'h0, 32'hFFFFF00D);
        run_op(0, 1, 4'd8, 32'h300, 32'hCAFEBABE, 32'h0, 2, 0, 4'b1111, 32'hCAFEBABE, 32'hFFFFF00D);
        // reset in BUSY with ack in the same cycle
        @(negedge clk);
        memRead = 1'b1; memWrite = 1'b0; memOp = 4'd3; addr = 32'h104;
        exp_q.push_back('{1'b0, 32'h104, 4'b1111, 32'h0});
        @(negedge clk);
        pop_check();
        nrst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF; memRead = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({bus_read, bus_write, stall, err}), 32'd0);
        chk("abort_addr", bus_addr, 32'd0);
        chk("abort_sel", 32'(bus_sel), 32'd0);
        chk("abort_load", loadData, 32'd0);
        nrst = 1'b1; bus_ack = 1'b0;
        run_op(1, 0, 4'd3, 32'h108, 32'h0, 32'h11223344, 1, 0, 4'b1111, 32'h0, 32'h11223344);
        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_extra_strobe", 32'({bus_read, bus_write, stall}), 32'd0);
        chk("q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
